// File: rtl/mc_control_if.sv
// Bus between the multicycle main-control sequencer and the MIPS-lite datapath.
// The controller side (master) reads the latched opcode and the memory-ready
// handshake, and drives every strobe, mux select and debug/status output.
interface mc_control_if #(
  parameter int CNT_W = 32
) ();
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pcwrite;
  logic             pcwritecond;
  logic             irwrite;
  logic             memread;
  logic             memwrite;
  logic             regwrite;
  logic             iord;
  logic             memtoreg;
  logic             regdst;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       pcsource;
  logic             aluop1;
  logic             aluop0;
  logic [3:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, mem_ready,
    output pcwrite, pcwritecond, irwrite, memread, memwrite, regwrite,
           iord, memtoreg, regdst, alusrca, alusrcb, pcsource,
           aluop1, aluop0, state, illegal, instr_count
  );

  modport slave (
    output opcode, mem_ready,
    input  pcwrite, pcwritecond, irwrite, memread, memwrite, regwrite,
           iord, memtoreg, regdst, alusrca, alusrcb, pcsource,
           aluop1, aluop0, state, illegal, instr_count
  );
endinterface

// File: rtl/mc_control.sv
// Multicycle main-control sequencer for the MIPS-lite datapath.
// Walks each instruction through fetch/decode/execute/memory/writeback,
// drives the datapath controls for the current state, stalls on mem_ready in
// the memory-access states and counts retired instructions.
// Strobes are gated with rst_n so they fall the instant reset is asserted,
// even in the middle of a stalled access.
module mc_control #(
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mc_control_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXEC  = 4'd6,
    S_RTWB    = 4'd7,
    S_BEQ     = 4'd8,
    S_JUMP    = 4'd9,
    S_ORIEXEC = 4'd10,
    S_ORIWB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  state_e           state_r;
  state_e           next_s;
  logic             illegal_r;
  logic [CNT_W-1:0] cnt_r;

  logic       pcwrite_s;
  logic       pcwritecond_s;
  logic       irwrite_s;
  logic       memread_s;
  logic       memwrite_s;
  logic       regwrite_s;
  logic       iord_s;
  logic       memtoreg_s;
  logic       regdst_s;
  logic       alusrca_s;
  logic [1:0] alusrcb_s;
  logic [1:0] pcsource_s;
  logic [1:0] aluop_s;
  logic       illegal_hit_s;
  logic       retire_s;

  // State register; reset always lands in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state and per-state datapath controls; unlisted signals stay 0.
  always_comb begin
    next_s        = S_FETCH;
    pcwrite_s     = 1'b0;
    pcwritecond_s = 1'b0;
    irwrite_s     = 1'b0;
    memread_s     = 1'b0;
    memwrite_s    = 1'b0;
    regwrite_s    = 1'b0;
    iord_s        = 1'b0;
    memtoreg_s    = 1'b0;
    regdst_s      = 1'b0;
    alusrca_s     = 1'b0;
    alusrcb_s     = 2'b00;
    pcsource_s    = 2'b00;
    aluop_s       = 2'b00;
    illegal_hit_s = 1'b0;
    retire_s      = 1'b0;
    case (state_r)
      S_FETCH: begin
        memread_s = 1'b1;
        alusrcb_s = 2'b01;
        // IR load and PC+4 only happen on the cycle memory delivers.
        irwrite_s = bus.mem_ready;
        pcwrite_s = bus.mem_ready;
        if (bus.mem_ready) begin
          next_s = S_DECODE;
        end else begin
          next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        alusrcb_s = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: next_s = S_MEMADR;
          OP_RTYPE:     next_s = S_RTEXEC;
          OP_BEQ:       next_s = S_BEQ;
          OP_J:         next_s = S_JUMP;
          OP_ORI:       next_s = S_ORIEXEC;
          default: begin
            next_s        = S_FETCH;
            illegal_hit_s = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
        if (bus.opcode == OP_LW) begin
          next_s = S_MEMRD;
        end else if (bus.opcode == OP_SW) begin
          next_s = S_MEMWR;
        end else begin
          next_s = S_FETCH;
        end
      end
      S_MEMRD: begin
        memread_s = 1'b1;
        iord_s    = 1'b1;
        if (bus.mem_ready) begin
          next_s = S_MEMWB;
        end else begin
          next_s = S_MEMRD;
        end
      end
      S_MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg_s = 1'b1;
        retire_s   = 1'b1;
        next_s     = S_FETCH;
      end
      S_MEMWR: begin
        memwrite_s = 1'b1;
        iord_s     = 1'b1;
        if (bus.mem_ready) begin
          retire_s = 1'b1;
          next_s   = S_FETCH;
        end else begin
          next_s = S_MEMWR;
        end
      end
      S_RTEXEC: begin
        alusrca_s = 1'b1;
        aluop_s   = 2'b10;
        next_s    = S_RTWB;
      end
      S_RTWB: begin
        regwrite_s = 1'b1;
        regdst_s   = 1'b1;
        retire_s   = 1'b1;
        next_s     = S_FETCH;
      end
      S_BEQ: begin
        alusrca_s     = 1'b1;
        aluop_s       = 2'b01;
        pcwritecond_s = 1'b1;
        pcsource_s    = 2'b01;
        retire_s      = 1'b1;
        next_s        = S_FETCH;
      end
      S_JUMP: begin
        pcwrite_s  = 1'b1;
        pcsource_s = 2'b10;
        retire_s   = 1'b1;
        next_s     = S_FETCH;
      end
      S_ORIEXEC: begin
        // ALU control picks OR from the opcode when ALUOp is 10.
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
        aluop_s   = 2'b10;
        next_s    = S_ORIWB;
      end
      S_ORIWB: begin
        regwrite_s = 1'b1;
        retire_s   = 1'b1;
        next_s     = S_FETCH;
      end
      default: begin
        next_s = S_FETCH;
      end
    endcase
  end

  // Illegal-opcode flag, one cycle after the offending DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= illegal_hit_s;
    end
  end

  // Retired-instruction counter; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (retire_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.pcwrite     = pcwrite_s & rst_n;
  assign bus.pcwritecond = pcwritecond_s & rst_n;
  assign bus.irwrite     = irwrite_s & rst_n;
  assign bus.memread     = memread_s & rst_n;
  assign bus.memwrite    = memwrite_s & rst_n;
  assign bus.regwrite    = regwrite_s & rst_n;
  assign bus.iord        = iord_s;
  assign bus.memtoreg    = memtoreg_s;
  assign bus.regdst      = regdst_s;
  assign bus.alusrca     = alusrca_s;
  assign bus.alusrcb     = alusrcb_s;
  assign bus.pcsource    = pcsource_s;
  assign bus.aluop1      = aluop_s[1];
  assign bus.aluop0      = aluop_s[0];
  assign bus.state       = state_r;
  assign bus.illegal     = illegal_r & rst_n;
  assign bus.instr_count = cnt_r;

endmodule
